uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Round-robin arbiter that shares one UART transmitter (UART_driver TX path) between NUM_REQ byte producers. Sits between the requesters and UART_driver's UART_Start/data_in/UART_Ready/UART_Busy handshake. Each accepted byte is latched, launched with a one-cycle start pulse and tracked until the driver returns to ready. Supports locked multi-byte bursts and a launch timeout.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- MAX_BURST, 16, max consecutive bytes per locked grant (1..255)
- START_TIMEOUT, 8, cycles to wait for uart_busy after launch (2..255)
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- req  in  NUM_REQ  per-requester byte-pending flag
- req_data  in  8*NUM_REQ  byte for requester i on bits [8i+7:8i]
- req_lock  in  NUM_REQ  hold grant after this byte (burst continuation)
- ack  out  NUM_REQ  one-cycle pulse: requester's byte accepted by driver
- done  out  NUM_REQ  one-cycle pulse: requester's byte fully transmitted
- grant_valid  out  1  a requester currently owns the transmitter
- grant_id  out  $clog2(NUM_REQ)  owner index (valid when grant_valid)
- uart_start  out  1  to UART_Start
- uart_data  out  8  to data_in
- uart_ready  in  1  from UART_Ready
- uart_busy  in  1  from UART_Busy
- timeout_err  out  1  one-cycle pulse: driver failed to go busy

## Operation
- States: IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE.
- IDLE: if |req and uart_ready: pick winner by round-robin starting at last_grant+1 mod NUM_REQ; register grant_id, grant_valid=1, latch req_data slice into uart_data, burst_cnt=0; go LAUNCH. Otherwise stay.
- LAUNCH: uart_start=1 for exactly this cycle; timeout counter cleared; go WAIT_BUSY.
- WAIT_BUSY: if uart_busy=1: pulse ack[grant_id] next cycle; go WAIT_DONE. Else count; at START_TIMEOUT cycles pulse timeout_err, no ack/done, last_grant=grant_id, grant_valid=0, go IDLE.
- WAIT_DONE: on uart_busy=0 and uart_ready=1: pulse done[grant_id]. Then, if req[grant_id] and req_lock[grant_id] and burst_cnt < MAX_BURST-1: relatch req_data slice, burst_cnt+1, go LAUNCH (no re-arbitration). Else last_grant=grant_id, grant_valid=0, go IDLE.
- req_lock is sampled at the same cycle as the done decision (requester presents next byte with lock held).
- Data is latched at grant/relaunch; req or req_data changes afterward do not affect the byte in flight.
- uart_data holds its value through WAIT_DONE; uart_start is 0 outside LAUNCH.
- Arbitration is only in IDLE; requests arriving mid-transfer wait.
- burst_cnt is 8 bits; MAX_BURST=1 disables bursts.
- Pointer: last_grant resets to NUM_REQ-1, so requester 0 wins first after reset.

## Timing
- Reset values: ack=0, done=0, grant_valid=0, grant_id=0, uart_start=0, uart_data=0x00, timeout_err=0, state IDLE, last_grant=NUM_REQ-1, burst_cnt=0.
- Reset mid-transfer: all return to reset values immediately; no ack/done for the aborted byte.
- Latency (driver idle, uart_ready=1): req seen cycle 0 -> uart_start high cycle 1 -> uart_busy high cycle 2 -> ack high cycle 3.
- done is high the cycle after the driver shows uart_ready=1, uart_busy=0.
- Locked burst: next uart_start is the cycle after done decision (LAUNCH), i.e. one idle cycle between stop bit end and next start pulse.
- ack and done are never high for two requesters in the same cycle; ack and done are never high together.
- Simultaneous req from all requesters: granted in strict rotation, each exactly once per NUM_REQ grants (unlocked).
- timeout_err fires exactly START_TIMEOUT cycles after entering WAIT_BUSY.

## Test plan
- Single request: req=0001, req_data[7:0]=0x55 -> uart_start pulse cycle 1 with uart_data=0x55, ack=0001 cycle 3, done=0001 after stop bit, grant_valid back to 0.
- Fairness: req=1111 held, data 0xA0..0xA3, no lock -> byte order 0xA0,0xA1,0xA2,0xA3,0xA0; grant_id 0,1,2,3,0.
- Locked burst: req=0010 with req_lock[1]=1, MAX_BURST=3, req[2] also pending -> three requester-1 bytes back-to-back, then grant_id=2; fourth lock cycle ignored.
- Timeout: uart_busy stuck 0 -> timeout_err pulse 8 cycles after entering WAIT_BUSY, no ack/done, next requester served.
- Reset mid-transfer: assert rst in WAIT_DONE -> all outputs reset values same cycle, no done; after release req=1000 only -> grant_id=3.
- Data stability: change req_data[7:0] 0x11->0x22 after grant -> driver transmits 0x11.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART TX driver among NUM_REQ byte producers; req->uart_start 1 cycle, ack 3 cycles.
// Requesters wait (req held) while the driver is owned; locked bursts keep the grant up to MAX_BURST bytes.
`default_nettype none

module uart_tx_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int MAX_BURST     = 16,
    parameter int START_TIMEOUT = 8,
    localparam int IW           = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [8*NUM_REQ-1:0]   req_data,
    input  logic [NUM_REQ-1:0]     req_lock,
    output logic [NUM_REQ-1:0]     ack,
    output logic [NUM_REQ-1:0]     done,
    output logic                   grant_valid,
    output logic [IW-1:0]          grant_id,
    output logic                   uart_start,
    output logic [7:0]             uart_data,
    input  logic                   uart_ready,
    input  logic                   uart_busy,
    output logic                   timeout_err
);

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    state_t              state;
    logic [IW-1:0]       last_grant;
    logic [7:0]          burst_cnt;
    logic [7:0]          tmo_cnt;

    logic [IW-1:0]       win_id;
    logic                win_vld;
    logic [7:0]          win_data;
    logic [7:0]          own_data;
    logic                own_lock;
    logic                burst_more;
    logic [NUM_REQ-1:0]  own_onehot;

    // Scan downward so the requester closest after last_grant is written last and wins.
    always_comb begin
        win_id  = '0;
        win_vld = 1'b0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            if (req[(int'(last_grant) + k) % NUM_REQ]) begin
                win_id  = IW'((int'(last_grant) + k) % NUM_REQ);
                win_vld = 1'b1;
            end
        end
    end

    always_comb begin
        win_data   = req_data[8*int'(win_id) +: 8];
        own_data   = req_data[8*int'(grant_id) +: 8];
        own_lock   = req[grant_id] & req_lock[grant_id];
        burst_more = int'(burst_cnt) < (MAX_BURST - 1);
        own_onehot = NUM_REQ'(1) << grant_id;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            last_grant  <= IW'(NUM_REQ - 1);
            burst_cnt   <= 8'd0;
            tmo_cnt     <= 8'd0;
            ack         <= '0;
            done        <= '0;
            grant_valid <= 1'b0;
            grant_id    <= '0;
            uart_start  <= 1'b0;
            uart_data   <= 8'h00;
            timeout_err <= 1'b0;
        end else begin
            ack         <= '0;
            done        <= '0;
            timeout_err <= 1'b0;
            uart_start  <= 1'b0;
            case (state)
                IDLE: begin
                    if (win_vld && uart_ready) begin
                        grant_id    <= win_id;
                        grant_valid <= 1'b1;
                        uart_data   <= win_data;
                        burst_cnt   <= 8'd0;
                        uart_start  <= 1'b1;
                        state       <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    tmo_cnt <= 8'd0;
                    state   <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (uart_busy) begin
                        ack   <= own_onehot;
                        state <= WAIT_DONE;
                    end else if (int'(tmo_cnt) == START_TIMEOUT - 1) begin
                        timeout_err <= 1'b1;
                        last_grant  <= grant_id;
                        grant_valid <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
                end
                WAIT_DONE: begin
                    if (!uart_busy && uart_ready) begin
                        done <= own_onehot;
                        // Lock is judged on the same cycle as completion: the owner must already show its next byte.
                        if (own_lock && burst_more) begin
                            uart_data  <= own_data;
                            burst_cnt  <= burst_cnt + 8'd1;
                            uart_start <= 1'b1;
                            state      <= LAUNCH;
                        end else begin
                            last_grant  <= grant_id;
                            grant_valid <= 1'b0;
                            state       <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    a_ack_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(ack));
    a_done_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(done));
    a_ack_done_excl: assert property (@(posedge clk) disable iff (rst) !(|ack && |done));
    a_start_in_launch: assert property (@(posedge clk) disable iff (rst) uart_start |-> state == LAUNCH);

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: behavioural UART driver plus a scoreboard of expected (owner, byte) launches.
module tb_uart_tx_arbiter;

    localparam int BYTE_CYC = 10;
    localparam int WAIT_LIM = 100;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  req_lock;
    logic [3:0]  ack;
    logic [3:0]  done;
    logic        grant_valid;
    logic [1:0]  grant_id;
    logic        uart_start;
    logic [7:0]  uart_data;
    logic        uart_ready;
    logic        uart_busy;
    logic        timeout_err;

    logic        stuck;
    int          drv_cnt;
    int          n_chk = 0;
    int          n_fail = 0;

    typedef struct {
        logic [1:0] id;
        logic [7:0] data;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [1:0]  inflight;
    logic        inflight_vld = 1'b0;

    uart_tx_arbiter #(
        .NUM_REQ(4),
        .MAX_BURST(3),
        .START_TIMEOUT(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req(req),
        .req_data(req_data),
        .req_lock(req_lock),
        .ack(ack),
        .done(done),
        .grant_valid(grant_valid),
        .grant_id(grant_id),
        .uart_start(uart_start),
        .uart_data(uart_data),
        .uart_ready(uart_ready),
        .uart_busy(uart_busy),
        .timeout_err(timeout_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    // Driver model: goes busy the cycle after a start pulse, busy for BYTE_CYC cycles.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            uart_busy  <= 1'b0;
            uart_ready <= 1'b1;
            drv_cnt    <= 0;
        end else if (uart_busy) begin
            if (drv_cnt == 1) begin
                uart_busy  <= 1'b0;
                uart_ready <= 1'b1;
            end
            drv_cnt <= drv_cnt - 1;
        end else if (uart_start && !stuck) begin
            uart_busy  <= 1'b1;
            uart_ready <= 1'b0;
            drv_cnt    <= BYTE_CYC;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] oh(input logic [1:0] i);
        oh = 4'b0001 << i;
    endfunction

    task automatic expect_byte(input logic [1:0] id, input logic [7:0] data);
        exp_t e;
        e.id   = id;
        e.data = data;
        exp_q.push_back(e);
    endtask

    // Completion is handled before launch so a burst relaunch in the done cycle is tracked correctly.
    always @(negedge clk) begin
        if (rst) begin
            inflight_vld = 1'b0;
        end else begin
            if (|done) begin
                check("done_owner_vld", 32'(inflight_vld), 32'd1);
                check("done_onehot", 32'(done), 32'(oh(inflight)));
                inflight_vld = 1'b0;
            end
            if (|ack) begin
                check("ack_owner_vld", 32'(inflight_vld), 32'd1);
                check("ack_onehot", 32'(ack), 32'(oh(inflight)));
                check("ack_done_excl", 32'(done), 32'd0);
            end
            if (uart_start) begin
                if (exp_q.size() == 0) begin
                    check("sb_unexpected_start", 32'd1, 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("sb_grant_id", 32'(grant_id), 32'(mon_e.id));
                    check("sb_data", 32'(uart_data), 32'(mon_e.data));
                    check("sb_grant_valid", 32'(grant_valid), 32'd1);
                    inflight     = mon_e.id;
                    inflight_vld = 1'b1;
                end
            end
        end
    end

    // which: 0 = ack, 1 = done, 2 = uart_start
    task automatic wait_evt(input int which, input string tag);
        bit hit = 1'b0;
        for (int i = 0; i < WAIT_LIM && !hit; i++) begin
            @(negedge clk);
            case (which)
                0:       hit = |ack;
                1:       hit = |done;
                default: hit = uart_start;
            endcase
        end
        check(tag, 32'(hit), 32'd1);
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        req      = '0;
        req_lock = '0;
        req_data = '0;
        stuck    = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int  k;
        bit  spurious;

        rst      = 1'b1;
        req      = '0;
        req_lock = '0;
        req_data = '0;
        stuck    = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_grant_valid", 32'(grant_valid), 32'd0);
        check("rst_grant_id", 32'(grant_id), 32'd0);
        check("rst_uart_start", 32'(uart_start), 32'd0);
        check("rst_uart_data", 32'(uart_data), 32'd0);
        check("rst_timeout", 32'(timeout_err), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Single request with exact latency
        expect_byte(2'd0, 8'h55);
        req_data[7:0] = 8'h55;
        req = 4'b0001;
        @(negedge clk);
        check("single_start_c1", 32'(uart_start), 32'd1);
        check("single_data_c1", 32'(uart_data), 32'h55);
        check("single_gid_c1", 32'(grant_id), 32'd0);
        @(negedge clk);
        check("single_start_c2", 32'(uart_start), 32'd0);
        check("single_ack_c2", 32'(ack), 32'd0);
        @(negedge clk);
        check("single_ack_c3", 32'(ack), 32'b0001);
        req = '0;
        wait_evt(1, "single_wait_done");
        check("single_done", 32'(done), 32'b0001);
        check("single_gv_low", 32'(grant_valid), 32'd0);

        // Fairness with all requesters pending
        do_reset();
        req_data = 32'hA3A2A1A0;
        expect_byte(2'd0, 8'hA0);
        expect_byte(2'd1, 8'hA1);
        expect_byte(2'd2, 8'hA2);
        expect_byte(2'd3, 8'hA3);
        expect_byte(2'd0, 8'hA0);
        req = 4'b1111;
        for (int i = 0; i < 5; i++) wait_evt(1, "fair_wait_done");
        req = '0;
        repeat (3) @(negedge clk);
        check("fair_idle", 32'(grant_valid), 32'd0);

        // Locked burst from requester 1 with requester 2 waiting
        do_reset();
        req_lock = 4'b0010;
        req_data[15:8]  = 8'hB0;
        req_data[23:16] = 8'hC0;
        expect_byte(2'd1, 8'hB0);
        expect_byte(2'd1, 8'hB1);
        expect_byte(2'd1, 8'hB2);
        expect_byte(2'd2, 8'hC0);
        req = 4'b0110;
        wait_evt(0, "burst_wait_ack0");
        req_data[15:8] = 8'hB1;
        wait_evt(1, "burst_wait_done0");
        check("burst_relaunch0", 32'(uart_start), 32'd1);
        check("burst_gv0", 32'(grant_valid), 32'd1);
        wait_evt(0, "burst_wait_ack1");
        req_data[15:8] = 8'hB2;
        wait_evt(1, "burst_wait_done1");
        check("burst_relaunch1", 32'(uart_start), 32'd1);
        wait_evt(0, "burst_wait_ack2");
        req_data[15:8] = 8'hB3;
        wait_evt(1, "burst_wait_done2");
        check("burst_end_start", 32'(uart_start), 32'd0);
        check("burst_end_gv", 32'(grant_valid), 32'd0);
        @(negedge clk);
        check("burst_next_gid", 32'(grant_id), 32'd2);
        check("burst_next_start", 32'(uart_start), 32'd1);
        req = '0;
        wait_evt(0, "burst_wait_ack3");
        wait_evt(1, "burst_wait_done3");
        req_lock = '0;

        // Launch timeout, then the next requester is served
        do_reset();
        stuck = 1'b1;
        req_data[7:0]  = 8'hD0;
        req_data[15:8] = 8'hD1;
        expect_byte(2'd0, 8'hD0);
        expect_byte(2'd1, 8'hD1);
        req = 4'b0011;
        wait_evt(2, "to_wait_start");
        k = 0;
        spurious = 1'b0;
        for (int i = 1; i <= 20 && k == 0; i++) begin
            @(negedge clk);
            if (|ack || |done) spurious = 1'b1;
            if (timeout_err) k = i;
        end
        check("to_cycles", 32'(k), 32'd9);
        check("to_no_ack_done", 32'(spurious), 32'd0);
        check("to_gv_low", 32'(grant_valid), 32'd0);
        stuck = 1'b0;
        req   = 4'b0010;
        @(negedge clk);
        check("to_pulse_len", 32'(timeout_err), 32'd0);
        check("to_next_gid", 32'(grant_id), 32'd1);
        wait_evt(0, "to_wait_ack");
        req = '0;
        wait_evt(1, "to_wait_done");

        // Reset while the driver is mid-byte
        do_reset();
        expect_byte(2'd0, 8'h77);
        req_data[7:0] = 8'h77;
        req = 4'b0001;
        wait_evt(0, "mrst_wait_ack");
        req = '0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        check("mrst_gv", 32'(grant_valid), 32'd0);
        check("mrst_gid", 32'(grant_id), 32'd0);
        check("mrst_data", 32'(uart_data), 32'd0);
        check("mrst_start", 32'(uart_start), 32'd0);
        check("mrst_ack", 32'(ack), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("mrst_no_done", 32'(done), 32'd0);
        end
        rst = 1'b0;
        expect_byte(2'd3, 8'h88);
        req_data[31:24] = 8'h88;
        req = 4'b1000;
        wait_evt(2, "mrst_wait_start");
        check("mrst_gid3", 32'(grant_id), 32'd3);
        wait_evt(0, "mrst_wait_ack3");
        req = '0;
        wait_evt(1, "mrst_wait_done3");

        // Data changed after grant must not affect the byte in flight
        do_reset();
        expect_byte(2'd0, 8'h11);
        req_data[7:0] = 8'h11;
        req = 4'b0001;
        wait_evt(2, "stab_wait_start");
        req_data[7:0] = 8'h22;
        wait_evt(0, "stab_wait_ack");
        check("stab_data_ack", 32'(uart_data), 32'h11);
        req = '0;
        wait_evt(1, "stab_wait_done");
        check("stab_data_done", 32'(uart_data), 32'h11);

        repeat (5) @(negedge clk);
        check("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
